// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced button front end that loads A, B and the opcode for the ALU
// and latches the returned flags while executing.
module alu_operand_loader #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_OPS         = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic [3:0]   op_sw,
    input  logic         btn_next,
    input  logic         btn_clear,
    input  logic         in_flag_c,
    input  logic         in_flag_n,
    input  logic         in_flag_v,
    input  logic         in_flag_z,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   operation,
    output logic         exec_valid,
    output logic [3:0]   flags_q,
    output logic         flags_valid,
    output logic         op_err,
    output logic [1:0]   state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] OPLIM = 5'(NUM_OPS);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_OP, EXEC} state_t;

    state_t        state_q;
    logic [N-1:0]  a_q, b_q;
    logic [3:0]    op_q, flags_r;
    logic          fv_q, err_q;
    logic [1:0]    s1_q, s2_q, db_q, db_d, dbp_q, pulse;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          next_p, clr_p;

    // Bit 0 is the next button, bit 1 the clear button.
    always_comb begin
        db_d  = db_q;
        cnt_d = '{default: '0};
        for (int i = 0; i < 2; i++)
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CMAX) db_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
    end

    assign pulse  = db_q & ~dbp_q;
    assign next_p = pulse[0];
    assign clr_p  = pulse[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            db_q  <= '0;
            dbp_q <= '0;
            cnt_q <= '{default: '0};
        end else begin
            s1_q  <= {btn_clear, btn_next};
            s2_q  <= s1_q;
            db_q  <= db_d;
            dbp_q <= db_q;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            flags_r <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (clr_p) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            flags_r <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: if (next_p) begin
                    a_q     <= sw;
                    state_q <= LOAD_B;
                end
                LOAD_B: if (next_p) begin
                    b_q     <= sw;
                    state_q <= LOAD_OP;
                end
                LOAD_OP: if (next_p) begin
                    if ({1'b0, op_sw} < OPLIM) begin
                        op_q    <= op_sw;
                        err_q   <= 1'b0;
                        state_q <= EXEC;
                    end else err_q <= 1'b1;
                end
                EXEC: begin
                    // A next pulse on the capture edge still captures, then leaves.
                    if (!fv_q) begin
                        flags_r <= {in_flag_c, in_flag_n, in_flag_v, in_flag_z};
                        fv_q    <= 1'b1;
                    end
                    if (next_p) begin
                        state_q <= LOAD_A;
                        fv_q    <= 1'b0;
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign operation   = op_q;
    assign exec_valid  = state_q == EXEC;
    assign flags_q     = flags_r;
    assign flags_valid = fv_q;
    assign op_err      = err_q;
    assign state       = state_q;
endmodule
